// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the unified memory port arbiter: the default data
// word width and the arbiter FSM state encodings.
//
// Contents:
//   WORD_SIZE    - default data word width (16)
//   arb_state_e  - arbiter FSM states (IDLE, IFETCH, DACCESS, DRAIN)
//   is_busy()    - true while a memory transaction is owned by the FSM
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

   localparam int WORD_SIZE = 16;

   // DRAIN is only ever entered when the posted write buffer is compiled in.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IFETCH  = 2'd1,
      DACCESS = 2'd2,
      DRAIN   = 2'd3
   } arb_state_e;

   function automatic logic is_busy(input arb_state_e s);
      return (s != IDLE);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_wbuf.sv
// -----------------------------------------------------------------------------
// mem_write_buffer
// One-entry posted write buffer. A store is captured in a single cycle and
// held (address + data + full flag) until the arbiter drains it to memory.
//
// Ports:
//   Clk        in   clock, rising edge
//   Reset_N    in   synchronous active-low reset (empties the buffer)
//   capture    in   load cap_addr/cap_data and mark the entry full
//   clear      in   mark the entry empty (buffered write has completed)
//   cap_addr   in   store address to capture
//   cap_data   in   store data to capture
//   full       out  entry holds a write not yet issued to memory
//   addr       out  buffered store address
//   data       out  buffered store data
//
// Only instantiated when MEM_WBUF_EN is defined.
// -----------------------------------------------------------------------------
module mem_write_buffer #(
   parameter int WORD_SIZE  = mem_port_arbiter_pkg::WORD_SIZE,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  Clk,
   input  logic                  Reset_N,
   input  logic                  capture,
   input  logic                  clear,
   input  logic [ADDR_WIDTH-1:0] cap_addr,
   input  logic [WORD_SIZE-1:0]  cap_data,
   output logic                  full,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [WORD_SIZE-1:0]  data
);

   // Capture wins over clear; the arbiter never asserts both in one cycle.
   always_ff @(posedge Clk) begin
      if (!Reset_N) begin
         full <= 1'b0;
      end else if (capture) begin
         full <= 1'b1;
      end else if (clear) begin
         full <= 1'b0;
      end
   end

   // Payload is qualified by full, so it needs no reset.
   always_ff @(posedge Clk) begin
      if (capture) begin
         addr <= cap_addr;
         data <= cap_data;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one unified memory port between the CPU instruction-fetch stage and
// the MEM stage. Data accesses take priority over fetches; at most one memory
// transaction is outstanding and the mem_* fields are registered and stable
// while mem_req is high. Completion is signalled by a one-cycle *_valid pulse
// in the same cycle as mem_ready.
//
// Parameters:
//   WORD_SIZE   data width (default 16)
//   ADDR_WIDTH  address width (default 16)
//
// Ports:
//   Clk, Reset_N            clock, synchronous active-low reset
//   i_req, i_addr           fetch request (held until i_valid)
//   i_data, i_valid         fetched word, completion pulse
//   d_req, d_we, d_addr,
//   d_wdata                 data request (held until d_valid)
//   d_rdata, d_valid        load data, completion pulse
//   mem_req, mem_we,
//   mem_addr, mem_wdata     registered memory request fields
//   mem_rdata, mem_ready    memory read data and completion
//
// Build option:
//   MEM_WBUF_EN  adds a one-entry posted write buffer: stores complete in one
//                IDLE cycle and are drained (DRAIN state) ahead of any other
//                access, so later loads and fetches observe the stored data.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int WORD_SIZE  = mem_port_arbiter_pkg::WORD_SIZE,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  Clk,
   input  logic                  Reset_N,
   // instruction fetch side
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic [WORD_SIZE-1:0]  i_data,
   output logic                  i_valid,
   // data side
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [WORD_SIZE-1:0]  d_wdata,
   output logic [WORD_SIZE-1:0]  d_rdata,
   output logic                  d_valid,
   // memory side
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [WORD_SIZE-1:0]  mem_wdata,
   input  logic [WORD_SIZE-1:0]  mem_rdata,
   input  logic                  mem_ready
);

   import mem_port_arbiter_pkg::*;

   arb_state_e state_q;
   arb_state_e state_d;

   logic grant_fetch;
   logic grant_data;
   logic done;

`ifdef MEM_WBUF_EN
   logic                  grant_drain;
   logic                  buf_capture;
   logic                  buf_clear;
   logic                  buf_full;
   logic [ADDR_WIDTH-1:0] buf_addr;
   logic [WORD_SIZE-1:0]  buf_data;

   mem_write_buffer #(
      .WORD_SIZE  (WORD_SIZE),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_wbuf (
      .Clk      (Clk),
      .Reset_N  (Reset_N),
      .capture  (buf_capture),
      .clear    (buf_clear),
      .cap_addr (d_addr),
      .cap_data (d_wdata),
      .full     (buf_full),
      .addr     (buf_addr),
      .data     (buf_data)
   );
`endif

   // Next-state, grants and completion pulses. Everything is gated by
   // Reset_N so no valid pulse can escape while reset is asserted, even if
   // the state register still holds a busy state before the reset edge.
   always_comb begin
      state_d     = state_q;
      grant_fetch = 1'b0;
      grant_data  = 1'b0;
      done        = 1'b0;
      i_valid     = 1'b0;
      d_valid     = 1'b0;
      i_data      = mem_rdata;
      d_rdata     = mem_rdata;
`ifdef MEM_WBUF_EN
      grant_drain = 1'b0;
      buf_capture = 1'b0;
      buf_clear   = 1'b0;
`endif
      if (Reset_N) begin
         case (state_q)
            IDLE: begin
`ifdef MEM_WBUF_EN
               // A pending posted write goes out before anything else so
               // every later access sees memory already updated.
               if (buf_full) begin
                  grant_drain = 1'b1;
                  state_d     = DRAIN;
               end else if (d_req && d_we) begin
                  // Buffer is empty here: absorb the store and retire it now.
                  buf_capture = 1'b1;
                  d_valid     = 1'b1;
               end else
`endif
               if (d_req) begin
                  grant_data = 1'b1;
                  state_d    = DACCESS;
               end else if (i_req) begin
                  grant_fetch = 1'b1;
                  state_d     = IFETCH;
               end
            end
            IFETCH: begin
               if (mem_ready) begin
                  i_valid = 1'b1;
                  done    = 1'b1;
                  state_d = IDLE;
               end
            end
            DACCESS: begin
               if (mem_ready) begin
                  d_valid = 1'b1;
                  done    = 1'b1;
                  state_d = IDLE;
               end
            end
`ifdef MEM_WBUF_EN
            DRAIN: begin
               // The posted store already signalled d_valid; drain is silent.
               if (mem_ready) begin
                  buf_clear = 1'b1;
                  done      = 1'b1;
                  state_d   = IDLE;
               end
            end
`endif
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_N) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Memory request register: fields are loaded only on a grant, so they stay
   // stable for the whole transaction. mem_ready outside a busy state is
   // ignored because done can only be raised from a busy state.
   always_ff @(posedge Clk) begin
      if (!Reset_N) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (grant_fetch) begin
         mem_req  <= 1'b1;
         mem_we   <= 1'b0;
         mem_addr <= i_addr;
      end else if (grant_data) begin
         mem_req   <= 1'b1;
         mem_we    <= d_we;
         mem_addr  <= d_addr;
         mem_wdata <= d_wdata;
`ifdef MEM_WBUF_EN
      end else if (grant_drain) begin
         mem_req   <= 1'b1;
         mem_we    <= 1'b1;
         mem_addr  <= buf_addr;
         mem_wdata <= buf_data;
`endif
      end else if (done && is_busy(state_q)) begin
         mem_req <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Table-driven bench for mem_port_arbiter with a bench-side memory model and
// per-requester scoreboard queues, plus hand-written multi-cycle sequences
// (contention, reset mid-transaction, stray ready, posted store).
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int W = 16;
   localparam int A = 16;

   logic         Clk = 1'b0;
   logic         Reset_N;
   logic         i_req;
   logic [A-1:0] i_addr;
   logic [W-1:0] i_data;
   logic         i_valid;
   logic         d_req;
   logic         d_we;
   logic [A-1:0] d_addr;
   logic [W-1:0] d_wdata;
   logic [W-1:0] d_rdata;
   logic         d_valid;
   logic         mem_req;
   logic         mem_we;
   logic [A-1:0] mem_addr;
   logic [W-1:0] mem_wdata;
   logic [W-1:0] mem_rdata;
   logic         mem_ready;

   always #5 Clk = ~Clk;

   mem_port_arbiter #(.WORD_SIZE(W), .ADDR_WIDTH(A)) dut (
      .Clk       (Clk),
      .Reset_N   (Reset_N),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_data    (i_data),
      .i_valid   (i_valid),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_valid   (d_valid),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
   );

   typedef struct {
      bit           is_data;
      bit           we;
      logic [A-1:0] addr;
      logic [W-1:0] wdata;
      int           wait_cyc;
      logic [W-1:0] exp;
   } vec_t;

   typedef struct {
      logic [W-1:0] data;
      bit           chk;
   } sb_t;

   sb_t          iq[$];
   sb_t          dq[$];
   vec_t         tbl[$];
   logic [W-1:0] mem_arr [logic [A-1:0]];

   int n_checks = 0;
   int n_fail   = 0;

   // memory model state
   bit           mem_en = 1'b1;
   int           mem_wait = 0;
   int           mem_cnt = 0;
   int           writes_seen = 0;
   logic [A-1:0] cap_addr;
   logic [W-1:0] cap_wdata;
   logic         cap_we;
   bit           drop_i = 1'b0;
   bit           drop_d = 1'b0;

   task automatic check16(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b required %b", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mkv(input bit is_data, input bit we, input logic [A-1:0] addr,
                                input logic [W-1:0] wdata, input int wait_cyc, input logic [W-1:0] exp);
      vec_t v;
      v.is_data = is_data; v.we = we; v.addr = addr;
      v.wdata = wdata; v.wait_cyc = wait_cyc; v.exp = exp;
      return v;
   endfunction

   // Memory responds mem_wait cycles after it first sees mem_req (0 = same cycle).
   task automatic mem_model();
      if (mem_ready) begin
         mem_ready = 1'b0;
         mem_rdata = 16'h0BAD;
         mem_cnt   = 0;
      end else if (mem_en && mem_req) begin
         if (mem_cnt >= mem_wait) begin
            mem_ready = 1'b1;
            cap_addr  = mem_addr;
            cap_we    = mem_we;
            cap_wdata = mem_wdata;
            if (mem_we) begin
               mem_arr[mem_addr] = mem_wdata;
               writes_seen++;
            end
            mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : 16'hDEAD;
         end else begin
            mem_cnt++;
         end
      end
   endtask

   task automatic monitor();
      sb_t e;
      if (i_valid && d_valid) begin
         n_checks++; n_fail++;
         $display("FAIL valid_excl: i_valid=1 d_valid=1 required at most one");
      end
      if (i_valid) begin
         if (iq.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL i_spurious: i_valid=1 required 0");
         end else begin
            e = iq.pop_front();
            check16("i_data", i_data, e.data);
         end
         drop_i = 1'b1;
      end
      if (d_valid) begin
         if (dq.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL d_spurious: d_valid=1 required 0");
         end else begin
            e = dq.pop_front();
            if (e.chk) check16("d_rdata", d_rdata, e.data);
         end
         drop_d = 1'b1;
      end
   endtask

   // One clock: requesters drop at the edge ending their valid cycle,
   // memory model acts on the falling edge, outputs sampled just after.
   task automatic step();
      @(posedge Clk);
      #1;
      if (drop_i) i_req = 1'b0;
      if (drop_d) d_req = 1'b0;
      drop_i = 1'b0;
      drop_d = 1'b0;
      @(negedge Clk);
      mem_model();
      #1;
      monitor();
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int  lat;
      bit  got;
      sb_t e;
      mem_wait = v.wait_cyc;
      mem_cnt  = 0;
      e.data   = v.exp;
      if (v.is_data) begin
         e.chk = !v.we;
         dq.push_back(e);
         d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_req = 1'b1;
      end else begin
         e.chk = 1'b1;
         iq.push_back(e);
         i_addr = v.addr; i_req = 1'b1;
      end
      got = 1'b0;
      lat = 0;
      while (!got && lat < 50) begin
         step();
         lat++;
         got = v.is_data ? d_valid : i_valid;
      end
      check1($sformatf("v%0d_done", idx), got, 1'b1);
      check_int($sformatf("v%0d_latency", idx), lat, v.wait_cyc + 1);
      check16($sformatf("v%0d_mem_addr", idx), cap_addr, v.addr);
      check1($sformatf("v%0d_mem_we", idx), cap_we, v.we);
      if (v.we) check16($sformatf("v%0d_mem_wdata", idx), cap_wdata, v.wdata);
      step();
   endtask

   initial begin
      int  cyc;
      int  d_cyc;
      int  i_cyc;
      sb_t e;
`ifdef MEM_WBUF_EN
      int  ws0;
      int  lat;
`endif

      mem_arr[16'h0010] = 16'h6A05;
      mem_arr[16'h0011] = 16'hA5A5;
      mem_arr[16'h0040] = 16'h1234;
      mem_arr[16'hFFFF] = 16'h0F0F;

      tbl.push_back(mkv(1'b0, 1'b0, 16'h0010, 16'h0000, 2, 16'h6A05));
      tbl.push_back(mkv(1'b1, 1'b0, 16'h0040, 16'h0000, 0, 16'h1234));
      tbl.push_back(mkv(1'b0, 1'b0, 16'h0011, 16'h0000, 1, 16'hA5A5));
      tbl.push_back(mkv(1'b1, 1'b0, 16'hFFFF, 16'h0000, 0, 16'h0F0F));
`ifndef MEM_WBUF_EN
      tbl.push_back(mkv(1'b1, 1'b1, 16'h0080, 16'hBEEF, 1, 16'h0000));
      tbl.push_back(mkv(1'b1, 1'b0, 16'h0080, 16'h0000, 3, 16'hBEEF));
`endif

      Reset_N = 1'b0;
      i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      mem_ready = 1'b0; mem_rdata = '0;

      // reset state
      step();
      step();
      check1("rst_mem_req", mem_req, 1'b0);
      check1("rst_mem_we", mem_we, 1'b0);
      check16("rst_mem_addr", mem_addr, 16'h0000);
      check16("rst_mem_wdata", mem_wdata, 16'h0000);
      check1("rst_i_valid", i_valid, 1'b0);
      check1("rst_d_valid", d_valid, 1'b0);
      Reset_N = 1'b1;
      step();

      foreach (tbl[k]) run_vec(tbl[k], k);

      // contention: data then fetch
      mem_wait = 1; mem_cnt = 0;
      e.data = 16'h1234; e.chk = 1'b1; dq.push_back(e);
      e.data = 16'h6A05; e.chk = 1'b1; iq.push_back(e);
      d_we = 1'b0; d_addr = 16'h0040; i_addr = 16'h0010;
      d_req = 1'b1; i_req = 1'b1;
      cyc = 0; d_cyc = -1; i_cyc = -1;
      while (i_cyc < 0 && cyc < 60) begin
         step();
         cyc++;
         if (cyc == 1) check16("cont_first_addr", mem_addr, 16'h0040);
         if (d_valid) d_cyc = cyc;
         if (i_valid) i_cyc = cyc;
      end
      check_int("cont_d_cycle", d_cyc, 2);
      check_int("cont_i_cycle", i_cyc, 5);
      step();

      // reset in the middle of a data access
      mem_en = 1'b0;
      d_we = 1'b0; d_addr = 16'h0040; d_req = 1'b1;
      step();
      step();
      check1("rstmid_mem_req_hi", mem_req, 1'b1);
      Reset_N = 1'b0;
      mem_ready = 1'b1;
      #1;
      check1("rstmid_d_valid", d_valid, 1'b0);
      check1("rstmid_i_valid", i_valid, 1'b0);
      d_req = 1'b0;
      step();
      check1("rstmid_mem_req_lo", mem_req, 1'b0);
      check16("rstmid_mem_addr", mem_addr, 16'h0000);
      Reset_N = 1'b1;
      step();

      // stray ready in IDLE
      mem_ready = 1'b1;
      #1;
      check1("stray_d_valid", d_valid, 1'b0);
      check1("stray_i_valid", i_valid, 1'b0);
      step();
      check1("stray_mem_req", mem_req, 1'b0);
      mem_en = 1'b1;
      mem_cnt = 0;

      // arbiter back in IDLE and fully functional after reset
      run_vec(tbl[0], 100);

`ifdef MEM_WBUF_EN
      // posted store followed immediately by a load of the same address
      mem_wait = 1; mem_cnt = 0;
      ws0 = writes_seen;
      e.data = 16'h0000; e.chk = 1'b0; dq.push_back(e);
      d_we = 1'b1; d_addr = 16'h0080; d_wdata = 16'hBEEF; d_req = 1'b1;
      #1;
      monitor();
      check1("wb_store_1cyc", d_valid, 1'b1);
      step();
      e.data = 16'hBEEF; e.chk = 1'b1; dq.push_back(e);
      d_we = 1'b0; d_addr = 16'h0080; d_req = 1'b1;
      lat = 0;
      while (!d_valid && lat < 50) begin
         step();
         lat++;
      end
      check1("wb_load_done", d_valid, 1'b1);
      check_int("wb_drain_first", writes_seen, ws0 + 1);
      check1("wb_load_we", cap_we, 1'b0);
      step();
`endif

      check_int("sb_empty", iq.size() + dq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running, required completion");
      $fatal(1);
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified 16-bit memory port between the pipelined CPU's instruction-fetch stage and its MEM stage. It serialises accesses with a request/ready handshake to memory and gives data accesses priority over fetches. The IF and MEM stages stall on their `*_req` until the matching `*_valid` pulse. An optional one-entry posted write buffer lets stores retire early.

## Interface
- `WORD_SIZE`, default 16: data width.
- `ADDR_WIDTH`, default 16: address width.
- `Clk`: in, 1 bit. Clock; all state updates on the rising edge.
- `Reset_N`: in, 1 bit. Reset, synchronous, active-low.
- `i_req`: in, 1 bit. Fetch request; held with `i_addr` stable until `i_valid`.
- `i_addr`: in, ADDR_WIDTH. Fetch address.
- `i_data`: out, WORD_SIZE. Fetched word; meaningful only while `i_valid`.
- `i_valid`: out, 1 bit. One-cycle completion pulse for the fetch.
- `d_req`: in, 1 bit. Data request; held with `d_we`/`d_addr`/`d_wdata` stable until `d_valid`.
- `d_we`: in, 1 bit. 1 = store, 0 = load.
- `d_addr`: in, ADDR_WIDTH. Data address.
- `d_wdata`: in, WORD_SIZE. Store data.
- `d_rdata`: out, WORD_SIZE. Load data; meaningful only while `d_valid`.
- `d_valid`: out, 1 bit. One-cycle completion pulse for a load or store.
- `mem_req`: out, 1 bit. Registered. Held high until `mem_ready`.
- `mem_we`: out, 1 bit. Registered write enable.
- `mem_addr`: out, ADDR_WIDTH. Registered address.
- `mem_wdata`: out, WORD_SIZE. Registered write data.
- `mem_rdata`: in, WORD_SIZE. Read data; valid with `mem_ready`.
- `mem_ready`: in, 1 bit. Memory completion, one cycle per transaction.

## Operation
- FSM states:
  - IDLE
  - IFETCH
  - DACCESS
  - DRAIN (DRAIN exists only with the buffer compiled in)
- IDLE grant priority, evaluated each edge:
  - DRAIN if the buffer is full;
  - else DACCESS if `d_req`;
  - else IFETCH if `i_req`;
  - else stay in IDLE.
- On a grant, the FSM latches the port fields into `mem_*` and sets `mem_req`=1 at that edge.
- In IFETCH or DACCESS with `mem_ready`=1:
  - The matching `*_valid` is driven combinationally for that cycle.
  - `i_data`/`d_rdata` pass `mem_rdata` through.
  - At the following edge, `mem_req` drops to 0 and the FSM returns to IDLE.
- A store completing in DACCESS pulses `d_valid`; `d_rdata` is don't-care.
- `mem_ready` while in IDLE is ignored and produces no valid pulse.
- When `i_req` and `d_req` are both high in IDLE, data wins. The fetch is granted at the first IDLE with no data request pending.
- A requester that drops its request mid-transaction is a protocol violation. The transaction still completes and its valid pulse is emitted.
- Back-to-back grants are allowed: a requester that re-raises its request at the edge ending its valid cycle is seen in IDLE the next cycle.

## Timing
- Reset (`Reset_N`=0 at an edge) forces:
  - state = IDLE;
  - `mem_req`, `mem_we` = 0;
  - `mem_addr`, `mem_wdata` = 0;
  - buffer empty.
- `i_valid`/`d_valid` are 0 throughout reset.
- Reset during a transaction abandons it. No valid pulse is emitted, and a later stray `mem_ready` is ignored.
- Latency, with request sampled in IDLE at edge t:
  - `mem_req` is high from cycle t+1.
  - Valid appears in the cycle of `mem_ready`; the minimum is cycle t+1 with a zero-wait memory.
- At most one memory transaction is outstanding. `mem_*` fields are stable while `mem_req`=1.

## Configuration
- `MEM_WBUF_EN` defined: adds a one-entry posted write buffer (address + data + full flag).
  - A store seen in IDLE with the buffer empty is captured at that edge, and `d_valid` is pulsed combinationally in that same IDLE cycle (1-cycle store).
  - A store arriving while the buffer is full waits for DRAIN to complete.
  - DRAIN issues the buffered write. On its `mem_ready` the buffer clears and no valid pulse is emitted.
  - Because DRAIN has top priority, any later load or fetch observes the stored data.
- `MEM_WBUF_EN` undefined: stores go through DACCESS like loads. DRAIN and the buffer logic are absent.

## Structure
- The shared header (alongside the opcode definitions) holds:
  - `WORD_SIZE`;
  - the FSM state encodings IDLE=2'd0, IFETCH=2'd1, DACCESS=2'd2, DRAIN=2'd3.
- Sub-module `mem_write_buffer`, instantiated only under `MEM_WBUF_EN`:
  - capture/clear ports;
  - `full`, `addr`, `data` outputs.
- Everything else lives in `mem_port_arbiter`.

## Test plan
- Fetch only: `i_req`=1, `i_addr`=16'h0010, memory readies 2 cycles after `mem_req` with data 16'h6A05. Expect `mem_addr`=16'h0010, `mem_we`=0, and one `i_valid` pulse with `i_data`=16'h6A05.
- Contention: `i_req` and `d_req` (load 16'h0040) both rise in the same IDLE cycle.
  - The data access is granted first and `d_valid` returns the memory word.
  - The fetch is issued the cycle after returning to IDLE.
  - No cycle has `i_valid`=`d_valid`=1.
- Store without `MEM_WBUF_EN`: store 16'hBEEF to 16'h0080. Expect `mem_we`=1, `mem_wdata`=16'hBEEF, and `d_valid` coinciding with `mem_ready`.
- Store with `MEM_WBUF_EN`: store 16'hBEEF to 16'h0080, then immediately load 16'h0080.
  - `d_valid` for the store fires in its IDLE cycle.
  - DRAIN precedes the load, and the load returns 16'hBEEF.
- Reset mid-DACCESS: pull `Reset_N` low while `mem_req`=1 and `mem_ready`=0. Expect next-cycle `mem_req`=0, state IDLE, and no valid pulse for a `mem_ready` arriving afterwards.
- Stray ready: pulse `mem_ready` while IDLE with no requests. Expect no valid pulse and `mem_req` staying 0.
